// File: rtl/minesweeper_pkg.sv
// Shared Minesweeper board definitions: cell word fields, neighbour offsets, sequencer states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package minesweeper_pkg;

    // Cell word layout: mine flag at MINE_BIT, neighbour count in bits [CNT_W-1:0]
    localparam int MINE_BIT = 4;
    localparam int CNT_W    = 4;

    // Slot 0 is the centre cell, slots 1..8 are the neighbours in raster order
    localparam logic [3:0] NB_LAST = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Row offset for slot k: (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1)
    function automatic int nb_dr(input logic [3:0] k);
        case (k)
            4'd1, 4'd2, 4'd3: return -1;
            4'd6, 4'd7, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    // Column offset for slot k, same ordering as nb_dr
    function automatic int nb_dc(input logic [3:0] k);
        case (k)
            4'd1, 4'd4, 4'd6: return -1;
            4'd3, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

endpackage

// File: rtl/board_neighbour_addr.sv
// Maps (row, col, slot k) to a linear board address and an in-bounds flag.
// Latency: purely combinational.
// Backpressure: none; out-of-bounds slots fold back onto the centre address.
module board_neighbour_addr
    import minesweeper_pkg::*;
#(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int ADDR_W = 12,
    parameter int ROW_W  = 3,
    parameter int COL_W  = 3
) (
    input  logic [ROW_W-1:0]  i_row,
    input  logic [COL_W-1:0]  i_col,
    input  logic [3:0]        i_k,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_bounds
);

    int   w_r;
    int   w_c;
    int   w_lin;
    logic w_inb;

    // Signed neighbour coordinates; no wrap-around, off-board slots reuse the centre address
    always_comb begin
        w_r   = int'(i_row) + nb_dr(i_k);
        w_c   = int'(i_col) + nb_dc(i_k);
        w_inb = (w_r >= 0) && (w_r < ROWS) && (w_c >= 0) && (w_c < COLS);
        if (w_inb) begin
            w_lin = w_r * COLS + w_c;
        end else begin
            w_lin = int'(i_row) * COLS + int'(i_col);
        end
    end

    assign o_addr      = ADDR_W'(w_lin);
    assign o_in_bounds = w_inb;

endmodule

// File: rtl/board_count_sequencer.sv
// Walks the board in raster order and writes each cell's neighbouring-mine count into its word.
// Latency: 11 cycles per cell (9 reads, 1 drain, 1 write); done pulses 11*ROWS*COLS+1 cycles after start.
// Backpressure: none; owns RAM port 1 while busy, start is ignored unless idle.
module board_count_sequencer
    import minesweeper_pkg::*;
#(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic              ram_wEn,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut1
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    seq_state_t              r_state;
    seq_state_t              w_state_nxt;
    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic [3:0]              r_k;
    logic                    r_prev_centre;
    logic                    r_prev_vld;
    logic [DATA_W-1:CNT_W]   r_centre_hi;
    logic [CNT_W-1:0]        r_count;
    logic [3:0]              w_k;
    logic [ADDR_W-1:0]       w_nb_addr;
    logic                    w_nb_inb;
    logic                    w_last_cell;
    logic                    w_last_col;
    logic                    w_absorb;
    logic                    w_unused_cnt;

    // The old count field of the centre word is replaced, never consumed
    assign w_unused_cnt = ^ram_dataOut1[CNT_W-1:0];

    assign w_last_col  = (r_col == COL_W'(COLS - 1));
    assign w_last_cell = w_last_col && (r_row == ROW_W'(ROWS - 1));
    // Outside SCAN the address unit points at the centre, which is what WRITE needs
    assign w_k         = (r_state == ST_SCAN) ? r_k : 4'd0;
    // Read data for the previous slot is on the bus in SCAN k>=1 and in DRAIN
    assign w_absorb    = ((r_state == ST_SCAN) && (r_k != 4'd0)) || (r_state == ST_DRAIN);

    board_neighbour_addr #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_nb_addr (
        .i_row       (r_row),
        .i_col       (r_col),
        .i_k         (w_k),
        .o_addr      (w_nb_addr),
        .o_in_bounds (w_nb_inb)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and RAM port / handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        ram_wEn     = 1'b0;
        ram_addr1   = '0;
        ram_dataIn  = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy      = 1'b1;
                ram_addr1 = w_nb_addr;
                if (r_k == NB_LAST) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                ram_wEn     = 1'b1;
                ram_addr1   = w_nb_addr;
                ram_dataIn  = {r_centre_hi, r_count};
                w_state_nxt = w_last_cell ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Cell walk counters, read-slot pipeline, centre latch and mine counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row         <= '0;
            r_col         <= '0;
            r_k           <= '0;
            r_prev_centre <= 1'b0;
            r_prev_vld    <= 1'b0;
            r_centre_hi   <= '0;
            r_count       <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_row <= '0;
                r_col <= '0;
                r_k   <= '0;
            end

            if (r_state == ST_SCAN) begin
                r_prev_centre <= (r_k == 4'd0);
                r_prev_vld    <= w_nb_inb;
                r_k           <= (r_k == NB_LAST) ? 4'd0 : r_k + 4'd1;
                if (r_k == 4'd0) begin
                    r_count <= '0;
                end
            end

            if (w_absorb) begin
                if (r_prev_centre) begin
                    r_centre_hi <= ram_dataOut1[DATA_W-1:CNT_W];
                end else if (r_prev_vld && ram_dataOut1[MINE_BIT]) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            if (r_state == ST_WRITE) begin
                if (w_last_cell) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_board_count_sequencer.sv
// Self-checking bench: a RAM model on port 1, directed and random boards, checked against a neighbour-count model.
// Latency: expects done in cycle 276 after the start cycle on a 5x5 board.
// Backpressure: exercises starts issued while busy and coincident with done.
module tb_board_count_sequencer;

    localparam int ROWS   = 5;
    localparam int COLS   = 5;
    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DONE_CYCLE = 11 * CELLS + 1;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_addr1;
    logic              ram_wEn;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut1;

    logic [DATA_W-1:0] mem  [0:CELLS-1];
    logic [DATA_W-1:0] init [0:CELLS-1];

    int n_checks = 0;
    int n_fail   = 0;
    int wen_cnt  = 0;
    int bad_addr = 0;

    board_count_sequencer #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .ram_addr1    (ram_addr1),
        .ram_wEn      (ram_wEn),
        .ram_dataIn   (ram_dataIn),
        .ram_dataOut1 (ram_dataOut1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM: registered read (old data on a write), write on wEn
    always @(posedge clk) begin
        if (int'(ram_addr1) < CELLS) begin
            ram_dataOut1 <= mem[int'(ram_addr1)];
            if (ram_wEn) begin
                mem[int'(ram_addr1)] = ram_dataIn;
                wen_cnt = wen_cnt + 1;
            end
        end else begin
            ram_dataOut1 <= 'x;
            if (busy || ram_wEn) bad_addr = bad_addr + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: count mine flags of the up-to-8 on-board neighbours of the original board
    function automatic logic [31:0] exp_word(input int r, input int c);
        int cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < ROWS) &&
                    (c + dc >= 0) && (c + dc < COLS)) begin
                    if (init[(r + dr) * COLS + (c + dc)][4]) cnt++;
                end
            end
        end
        return {init[r * COLS + c][31:4], 4'(cnt)};
    endfunction

    // 0: mine at (0,0)  1: mine at (2,2)  2: all mines  3: all 0xABCDE010  4: random
    task automatic load_board(input int kind);
        logic [31:0] w;
        for (int i = 0; i < CELLS; i++) begin
            case (kind)
                0: w = (i == 0)  ? 32'h0000_0010 : 32'h0;
                1: w = (i == 12) ? 32'h0000_0010 : 32'h0;
                2: w = 32'h0000_0010;
                3: w = 32'hABCD_E010;
                default: begin
                    w    = $urandom;
                    w[4] = ($urandom_range(0, 2) == 0);
                end
            endcase
            init[i] = w;
            mem[i]  = w;
        end
    endtask

    task automatic check_board(input string tag);
        for (int i = 0; i < CELLS; i++) begin
            check_val($sformatf("%s cell(%0d,%0d)", tag, i / COLS, i % COLS),
                      mem[i], exp_word(i / COLS, i % COLS));
        end
    endtask

    // Start a pass; cycle 1 is the cycle after the accepting edge. Optionally re-pulse start
    // at cycles 5, 50 and 276 (the last coincides with done).
    task automatic run_pass(input string tag, input bit poke);
        int first_done = 0;
        int done_cnt   = 0;
        int busy_gap   = 0;
        wen_cnt  = 0;
        bad_addr = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
            end
            if (first_done == 0 && !done && !busy) busy_gap++;
            start = poke && (n == 5 || n == 50 || n == DONE_CYCLE);
            @(negedge clk);
        end
        start = 1'b0;
        check_val({tag, " done_cycle"}, first_done, DONE_CYCLE);
        check_val({tag, " done_pulses"}, done_cnt, 1);
        check_val({tag, " busy_gaps"}, busy_gap, 0);
        check_val({tag, " idle_busy"}, {31'b0, busy}, 0);
        check_val({tag, " writes"}, wen_cnt, CELLS);
        check_val({tag, " bad_addr"}, bad_addr, 0);
        check_board(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < CELLS; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_val("rst busy",   {31'b0, busy},    0);
        check_val("rst done",   {31'b0, done},    0);
        check_val("rst wEn",    {31'b0, ram_wEn}, 0);
        check_val("rst addr",   {20'b0, ram_addr1}, 0);
        check_val("rst dataIn", ram_dataIn, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        load_board(0); run_pass("corner", 1'b0);
        load_board(1); run_pass("centre", 1'b0);
        load_board(2); run_pass("all", 1'b0);
        load_board(3); run_pass("upper", 1'b1);
        load_board(4); run_pass("rand0", 1'b0);
        load_board(4); run_pass("rand1", 1'b1);

        // Abort a pass with reset at cycle 100, then rerun over the partially written board
        load_board(4);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("midrst wEn",  {31'b0, ram_wEn}, 0);
        check_val("midrst busy", {31'b0, busy},    0);
        check_val("midrst addr", {20'b0, ram_addr1}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_pass("rerun", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
